// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared types and constants for the main-memory responder.
//   - state_t      : responder FSM states
//   - DEF_*        : default parameter values of main_mem_responder
//   - OFF_BITS / IDX_BITS / CNT_BITS : widths derived from the defaults
//   - cnt_width()  : counter width for an arbitrary LATENCY / LINE_WORDS pair
package main_mem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_LATENCY     = 10;
  localparam int DEF_DEPTH_WORDS = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RDBURST = 3'd2,
    WRBURST = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One counter serves both the latency countdown (max LATENCY-1) and the
  // beat index (max LINE_WORDS-1), so it is sized for the larger of the two.
  function automatic int cnt_width(input int latency, input int line_words);
    int m;
    m = (latency > line_words) ? latency : line_words;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int OFF_BITS = $clog2(DEF_LINE_WORDS);
  localparam int IDX_BITS = $clog2(DEF_DEPTH_WORDS);
  localparam int CNT_BITS = cnt_width(DEF_LATENCY, DEF_LINE_WORDS);

endpackage

// File: rtl/main_mem_arb.sv
// main_mem_arb: two-requester arbiter for the main-memory responder.
// Grant is combinational from the requests and a priority bit.
// Optional feature macro: MAIN_MEM_RR_EN (round-robin); when undefined,
// port 1 always wins a tie.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req1, req2  : pending requests from port 1 / port 2
//   take        : the responder accepts the current grant this cycle
//   gnt1, gnt2  : one-hot (or zero) combinational grant
module main_mem_arb (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic req2,
  input  logic take,
  output logic gnt1,
  output logic gnt2
);

  // 0 favours port 1, 1 favours port 2.
  logic prio_q;

  assign gnt1 = req1 & (~req2 | ~prio_q);
  assign gnt2 = req2 & (~req1 |  prio_q);

`ifdef MAIN_MEM_RR_EN
  // After each grant the favoured port becomes the one that just lost out.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (take) begin
      prio_q <= gnt1;
    end
  end
`else
  // Fixed priority: port 1 is always favoured.
  logic unused_ctl;
  assign unused_ctl = reset ^ take;

  always_ff @(posedge clk) begin
    prio_q <= 1'b0;
  end
`endif

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: backing store behind the dual-ported data cache.
// Accepts line refills and writebacks from two cache ports, waits LATENCY
// cycles, then streams LINE_WORDS 32-bit beats, one per cycle.
// Optional feature macro: MAIN_MEM_RR_EN (round-robin port arbitration,
// implemented in main_mem_arb).
// Ports (suffix 2 = second pipe):
//   clk, reset              : clock, synchronous active-high reset
//   memreq*, memrw*         : request, direction (0 read, 1 write)
//   memaddr*, memwdata*     : byte address, writeback word for current beat
//   memack*                 : one-cycle acceptance pulse
//   memrvalid*, memwready*  : read beat valid / write beat strobe
//   memrdata                : shared read data, 0 outside read beats
//   memlast                 : final beat of either direction
//   memdone*                : one-cycle completion pulse
//   busy                    : FSM not in IDLE
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq,
  input  logic        memreq2,
  input  logic        memrw,
  input  logic        memrw2,
  input  logic [31:0] memaddr,
  input  logic [31:0] memaddr2,
  input  logic [31:0] memwdata,
  input  logic [31:0] memwdata2,
  output logic        memack,
  output logic        memack2,
  output logic        memrvalid,
  output logic        memrvalid2,
  output logic        memwready,
  output logic        memwready2,
  output logic [31:0] memrdata,
  output logic        memlast,
  output logic        memdone,
  output logic        memdone2,
  output logic        busy
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int CNT_W  = cnt_width(LATENCY, LINE_WORDS);

  localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               port_q;   // 0 = port 1, 1 = port 2
  logic               rw_q;
  logic [LINE_W-1:0]  line_q;

  logic               gnt1, gnt2, take;
  logic [31:0]        sel_addr;
  logic               sel_rw;
  logic [IDX_W-1:0]   beat_idx;
  logic [DATA_W-1:0]  wdata_sel;
  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

  // Byte-lane bits, in-line offset and bits above the array are ignored.
  logic unused_addr;
  assign unused_addr = ^{sel_addr[31:IDX_W+2], sel_addr[OFF_W+1:0]};

  assign take = (state_q == IDLE) & (memreq | memreq2);

  main_mem_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req1  (memreq),
    .req2  (memreq2),
    .take  (take),
    .gnt1  (gnt1),
    .gnt2  (gnt2)
  );

  assign sel_addr  = gnt2 ? memaddr2 : memaddr;
  assign sel_rw    = gnt2 ? memrw2   : memrw;
  assign wdata_sel = port_q ? memwdata2 : memwdata;
  // The line base is aligned, so beat k is just the counter in the offset bits.
  assign beat_idx  = {line_q, cnt_q[OFF_W-1:0]};

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = rw_q ? WRBURST : RDBURST;
      RDBURST,
      WRBURST: if (cnt_q == LAST_BEAT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- counters and latched grant ----
  // The counter is loaded with LATENCY-1 at grant, counts down through WAIT
  // and leaves WAIT at zero, which is also beat 0 of the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      port_q <= 1'b0;
      rw_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            cnt_q  <= LAT_M1;
            port_q <= gnt2;
            rw_q   <= sel_rw;
          end
        end
        WAIT:    cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        RDBURST,
        WRBURST: cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
        default: cnt_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      line_q <= sel_addr[IDX_W+1:OFF_W+2];
    end
  end

  // ---- word array ----
  // A write beat coinciding with reset is dropped, so an interrupted burst
  // leaves only the beats that completed before reset.
  always_ff @(posedge clk) begin
    if ((state_q == WRBURST) && !reset) begin
      mem_q[beat_idx] <= wdata_sel;
    end
  end

  // ---- outputs ----
  always_comb begin
    memack     = 1'b0;
    memack2    = 1'b0;
    memrvalid  = 1'b0;
    memrvalid2 = 1'b0;
    memwready  = 1'b0;
    memwready2 = 1'b0;
    memrdata   = '0;
    memlast    = 1'b0;
    memdone    = 1'b0;
    memdone2   = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      WAIT: begin
        // Only the first WAIT cycle still holds the freshly loaded count.
        if (cnt_q == LAT_M1) begin
          memack  = ~port_q;
          memack2 =  port_q;
        end
      end
      RDBURST: begin
        memrvalid  = ~port_q;
        memrvalid2 =  port_q;
        memrdata   = mem_q[beat_idx];
        memlast    = (cnt_q == LAST_BEAT);
      end
      WRBURST: begin
        memwready  = ~port_q;
        memwready2 =  port_q;
        memlast    = (cnt_q == LAST_BEAT);
      end
      DONE: begin
        memdone  = ~port_q;
        memdone2 =  port_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        memreq, memreq2, memrw, memrw2;
  logic [31:0] memaddr, memaddr2, memwdata, memwdata2;
  logic        memack, memack2, memrvalid, memrvalid2, memwready, memwready2;
  logic [31:0] memrdata;
  logic        memlast, memdone, memdone2, busy;

  logic        l1_req;
  logic [31:0] l1_addr;
  logic        l1_ack, l1_ack2, l1_rvalid, l1_rvalid2, l1_wready, l1_wready2;
  logic [31:0] l1_rdata;
  logic        l1_last, l1_done, l1_done2, l1_busy;

  main_mem_responder dut (
    .clk(clk), .reset(reset),
    .memreq(memreq), .memreq2(memreq2), .memrw(memrw), .memrw2(memrw2),
    .memaddr(memaddr), .memaddr2(memaddr2),
    .memwdata(memwdata), .memwdata2(memwdata2),
    .memack(memack), .memack2(memack2),
    .memrvalid(memrvalid), .memrvalid2(memrvalid2),
    .memwready(memwready), .memwready2(memwready2),
    .memrdata(memrdata), .memlast(memlast),
    .memdone(memdone), .memdone2(memdone2), .busy(busy)
  );

  main_mem_responder #(.LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .memreq(l1_req), .memreq2(1'b0), .memrw(1'b0), .memrw2(1'b0),
    .memaddr(l1_addr), .memaddr2(32'h0),
    .memwdata(32'h0), .memwdata2(32'h0),
    .memack(l1_ack), .memack2(l1_ack2),
    .memrvalid(l1_rvalid), .memrvalid2(l1_rvalid2),
    .memwready(l1_wready), .memwready2(l1_wready2),
    .memrdata(l1_rdata), .memlast(l1_last),
    .memdone(l1_done), .memdone2(l1_done2), .busy(l1_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent line_op.
  int          t_req, t_ack, t_first, t_last, t_done, nb, xerr;
  bit          tmo;
  logic [31:0] wbuf [4];
  logic [31:0] rbuf [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    memreq = 1'b0; memreq2 = 1'b0; l1_req = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Issues one line request on a port, supplies write beats from wbuf,
  // captures read beats into rbuf and records event cycles.
  task automatic line_op(input int port, input logic rw, input logic [31:0] addr);
    bit acked, fin, a, rv, wr, dn, oth;
    tmo = 1'b0; xerr = 0; nb = 0; acked = 1'b0; fin = 1'b0;
    t_ack = -1; t_first = -1; t_last = -1; t_done = -1;
    for (int k = 0; k < 4; k++) rbuf[k] = 32'h0;
    step();
    if (port == 1) begin memreq = 1'b1; memrw = rw; memaddr = addr; end
    else begin memreq2 = 1'b1; memrw2 = rw; memaddr2 = addr; end
    t_req = cyc;
    for (int i = 0; i < 200 && !fin; i++) begin
      step();
      if (acked && cyc == t_ack + 1) begin
        if (port == 1) memreq = 1'b0; else memreq2 = 1'b0;
      end
      a   = (port == 1) ? memack    : memack2;
      rv  = (port == 1) ? memrvalid : memrvalid2;
      wr  = (port == 1) ? memwready : memwready2;
      dn  = (port == 1) ? memdone   : memdone2;
      oth = (port == 1) ? (memack2 | memrvalid2 | memwready2 | memdone2)
                        : (memack  | memrvalid  | memwready  | memdone);
      if (oth) xerr++;
      if (a) begin
        if (acked) xerr++;
        else t_ack = cyc;
        acked = 1'b1;
      end
      if (rv) begin
        if (nb == 0) t_first = cyc;
        if (nb < 4) rbuf[nb] = memrdata;
        nb++;
      end
      if (wr) begin
        if (nb == 0) t_first = cyc;
        if (port == 1) memwdata = wbuf[nb % 4]; else memwdata2 = wbuf[nb % 4];
        nb++;
      end
      if (memlast) t_last = cyc;
      if (dn) begin t_done = cyc; fin = 1'b1; end
    end
    if (!fin) tmo = 1'b1;
    memreq = 1'b0; memreq2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memreq = 1'b0; memreq2 = 1'b0; memrw = 1'b0; memrw2 = 1'b0;
    memaddr = 32'h0; memaddr2 = 32'h0; memwdata = 32'h0; memwdata2 = 32'h0;
    l1_req = 1'b0; l1_addr = 32'h0;
    repeat (3) step();
    n_tests++;
    if ({memack, memack2, memrvalid, memrvalid2, memwready, memwready2,
         memlast, memdone, memdone2, busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 0", {memack, memack2, memrvalid,
               memrvalid2, memwready, memwready2, memlast, memdone, memdone2, busy});
    end
    n_tests++;
    if (memrdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", memrdata);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_refill();
    logic [31:0] exp_d [4];
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wbuf = exp_d;
    line_op(1, 1'b1, 32'h0000_0100);   // words 0x40..0x43
    n_tests++;
    if (tmo || t_done != t_req + 15 || nb != 4 || xerr != 0) begin
      n_fail++;
      $display("FAIL preload_write: done@+%0d beats %0d xerr %0d expected +15/4/0",
               t_done - t_req, nb, xerr);
    end
    line_op(1, 1'b0, 32'h0000_0104);
    n_tests++;
    if (t_ack != t_req + 1) begin
      n_fail++; $display("FAIL refill_ack: got +%0d expected +1", t_ack - t_req);
    end
    n_tests++;
    if (t_first != t_req + 11) begin
      n_fail++; $display("FAIL refill_first: got +%0d expected +11", t_first - t_req);
    end
    n_tests++;
    if (t_last != t_req + 14) begin
      n_fail++; $display("FAIL refill_last: got +%0d expected +14", t_last - t_req);
    end
    n_tests++;
    if (t_done != t_req + 15 || tmo) begin
      n_fail++; $display("FAIL refill_done: got +%0d expected +15", t_done - t_req);
    end
    n_tests++;
    if (nb != 4 || xerr != 0) begin
      n_fail++; $display("FAIL refill_beats: got %0d beats %0d stray expected 4/0", nb, xerr);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rbuf[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL refill_data%0d: got %h expected %h", k, rbuf[k], exp_d[k]);
      end
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || memrdata !== 32'h0) begin
      n_fail++; $display("FAIL refill_idle: busy %b rdata %h expected 0/0", busy, memrdata);
    end
  endtask

  task automatic test_writeback_read();
    logic [31:0] exp_d [4];
    exp_d = '{32'h11, 32'h12, 32'h13, 32'h14};
    wbuf = exp_d;
    line_op(2, 1'b1, 32'h0000_0200);
    n_tests++;
    if (tmo || t_ack != t_req + 1 || t_first != t_req + 11 || t_last != t_req + 14 || xerr != 0) begin
      n_fail++;
      $display("FAIL wb_timing: ack +%0d first +%0d last +%0d xerr %0d expected +1/+11/+14/0",
               t_ack - t_req, t_first - t_req, t_last - t_req, xerr);
    end
    line_op(2, 1'b0, 32'h0000_020C);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rbuf[k] !== exp_d[k] || tmo || xerr != 0) begin
        n_fail++; $display("FAIL wb_read%0d: got %h expected %h", k, rbuf[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_tie();
    int t, a1, a2, n2;
    logic [31:0] rb2 [4];
    pulse_reset();
    a1 = -1; a2 = -1; n2 = 0;
    step();
    memreq = 1'b1; memrw = 1'b0; memaddr = 32'h0000_0104;
    memreq2 = 1'b1; memrw2 = 1'b0; memaddr2 = 32'h0000_0200;
    t = cyc;
    for (int i = 0; i < 80; i++) begin
      step();
      if (a1 >= 0 && cyc == a1 + 1) memreq = 1'b0;
      if (a2 >= 0 && cyc == a2 + 1) memreq2 = 1'b0;
      if (memack && a1 < 0) a1 = cyc;
      if (memack2 && a2 < 0) a2 = cyc;
      if (memrvalid2) begin
        if (n2 < 4) rb2[n2] = memrdata;
        n2++;
      end
      if (memdone2) break;
    end
    memreq = 1'b0; memreq2 = 1'b0;
    n_tests++;
    if (a1 != t + 1) begin
      n_fail++; $display("FAIL tie_ack1: got +%0d expected +1", a1 - t);
    end
    n_tests++;
    if (a2 != t + 17) begin
      n_fail++; $display("FAIL tie_ack2: got +%0d expected +17", a2 - t);
    end
    n_tests++;
    if (n2 != 4 || rb2[0] !== 32'h11 || rb2[3] !== 32'h14) begin
      n_fail++; $display("FAIL tie_data2: beats %0d first %h last %h expected 4/11/14",
                         n2, rb2[0], rb2[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int ack, k;
    logic [31:0] d [4];
    d = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    wbuf = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    line_op(1, 1'b1, 32'h0000_0300);
    ack = -1; k = 0;
    step();
    memreq = 1'b1; memrw = 1'b1; memaddr = 32'h0000_0300;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack >= 0 && cyc == ack + 1) memreq = 1'b0;
      if (memack && ack < 0) ack = cyc;
      if (memwready) begin
        if (k == 2) begin
          reset = 1'b1; memreq = 1'b0;
          break;
        end
        memwdata = d[k];
        k++;
      end
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || memwready !== 1'b0 || k != 2) begin
      n_fail++; $display("FAIL midrst_idle: busy %b wready %b beats %0d expected 0/0/2",
                         busy, memwready, k);
    end
    reset = 1'b0;
    line_op(1, 1'b0, 32'h0000_0300);
    n_tests++;
    if (rbuf[0] !== 32'hD0 || rbuf[1] !== 32'hD1) begin
      n_fail++; $display("FAIL midrst_written: got %h %h expected d0 d1", rbuf[0], rbuf[1]);
    end
    n_tests++;
    if (rbuf[2] !== 32'hE2 || rbuf[3] !== 32'hE3) begin
      n_fail++; $display("FAIL midrst_kept: got %h %h expected e2 e3", rbuf[2], rbuf[3]);
    end
  endtask

  task automatic test_arbitration();
    int ord [4];
    int exp_o [4];
    int ng, la1, la2;
    bit idle;
`ifdef MAIN_MEM_RR_EN
    exp_o = '{1, 2, 1, 2};
`else
    exp_o = '{1, 1, 1, 1};
`endif
    ord = '{0, 0, 0, 0};
    pulse_reset();
    ng = 0; la1 = -10; la2 = -10;
    memrw = 1'b0; memaddr = 32'h0000_0104;
    memrw2 = 1'b0; memaddr2 = 32'h0000_0200;
    for (int i = 0; i < 150 && ng < 4; i++) begin
      step();
      memreq  = (cyc != la1 + 1);
      memreq2 = (cyc != la2 + 1);
      if (memack)  begin if (ng < 4) ord[ng] = 1; ng++; la1 = cyc; end
      if (memack2) begin if (ng < 4) ord[ng] = 2; ng++; la2 = cyc; end
    end
    step();
    memreq = 1'b0; memreq2 = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      step();
      idle = (busy == 1'b0);
    end
    n_tests++;
    if (ng != 4 || !idle) begin
      n_fail++; $display("FAIL arb_count: got %0d grants idle %b expected 4/1", ng, idle);
    end
    for (int g = 0; g < 4; g++) begin
      n_tests++;
      if (ord[g] != exp_o[g]) begin
        n_fail++; $display("FAIL arb_order%0d: got port %0d expected port %0d", g, ord[g], exp_o[g]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    exp_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    wbuf = exp_d;
    line_op(1, 1'b1, 32'hFFFF_FFF0);
    n_tests++;
    if (tmo || nb != 4) begin
      n_fail++; $display("FAIL wrap_write: beats %0d timeout %b expected 4/0", nb, tmo);
    end
    line_op(1, 1'b0, 32'h0000_0FF0);   // words 1020..1023
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rbuf[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL wrap_read%0d: got %h expected %h", k, rbuf[k], exp_d[k]);
      end
    end
    line_op(2, 1'b0, 32'h0000_1FF8);   // aliases to the same line
    n_tests++;
    if (rbuf[0] !== 32'hC0 || rbuf[3] !== 32'hC3) begin
      n_fail++; $display("FAIL wrap_alias: got %h %h expected c0 c3", rbuf[0], rbuf[3]);
    end
  endtask

  task automatic test_latency1();
    int t, a, f, d;
    a = -1; f = -1; d = -1;
    step();
    l1_req = 1'b1; l1_addr = 32'h0000_0040;
    t = cyc;
    for (int i = 0; i < 30 && d < 0; i++) begin
      step();
      if (a >= 0 && cyc == a + 1) l1_req = 1'b0;
      if (l1_ack && a < 0) a = cyc;
      if (l1_rvalid && f < 0) f = cyc;
      if (l1_done) d = cyc;
    end
    l1_req = 1'b0;
    n_tests++;
    if (a != t + 1) begin
      n_fail++; $display("FAIL lat1_ack: got +%0d expected +1", a - t);
    end
    n_tests++;
    if (f != t + 2) begin
      n_fail++; $display("FAIL lat1_first: got +%0d expected +2", f - t);
    end
    n_tests++;
    if (d != t + 6) begin
      n_fail++; $display("FAIL lat1_done: got +%0d expected +6", d - t);
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback_read();
    test_tie();
    test_reset_mid_burst();
    test_arbitration();
    test_wrap();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Backing-store responder on the far side of the dual-ported data-cache `memory_system`. It serves line refills (read misses) and dirty-line writebacks from the two cache request ports, one for each superscalar pipe. Each accepted request waits a fixed main-memory latency, then streams one cache line as one 32-bit word per cycle. The block owns the word array that models main memory, and it arbitrates between the two ports.

## Interface
Parameters:
- `LINE_WORDS`, default 4: words per cache line; a power of two, at least 2.
- `LATENCY`, default 10: cycles from acceptance to the first beat; at least 1.
- `DEPTH_WORDS`, default 1024: size of the word array; a power of two.

Ports (the suffix `2` marks the second pipe's port):
- `clk`  in  1  single clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `memreq`, `memreq2`  in  1  request from the cache port.
- `memrw`, `memrw2`  in  1  0 = line read (refill), 1 = line write (writeback).
- `memaddr`, `memaddr2`  in  32  byte address; bits [1:0] and the in-line offset bits are ignored.
- `memwdata`, `memwdata2`  in  32  writeback word for the current beat.
- `memack`, `memack2`  out  1  one-cycle acceptance pulse.
- `memrvalid`, `memrvalid2`  out  1  read beat valid.
- `memwready`, `memwready2`  out  1  write beat strobe; `memwdata*` is sampled at this edge.
- `memrdata`  out  32  read beat data; shared by both ports and qualified by `memrvalid*`.
- `memlast`  out  1  marks the final beat of either direction.
- `memdone`, `memdone2`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: sample the requests; on a grant go to WAIT.
  - WAIT: count down the latency; at zero go to RDBURST or WRBURST.
  - RDBURST / WRBURST: stream the beats; after the last beat go to DONE.
  - DONE: pulse `memdone*`, return to IDLE.
- Line base word index = `addr[31:2]` with the low log2(`LINE_WORDS`) bits cleared, taken modulo `DEPTH_WORDS`.
- Beat k (k = 0 … `LINE_WORDS`-1) addresses base+k. Beats do not wrap across lines; addresses above the array alias modulo `DEPTH_WORDS`.
- Arbitration happens only in IDLE. If both ports request in the same cycle, port 1 (no suffix) wins; round-robin mode is covered in Configuration.
- The losing port, and any request raised while `busy`, stays pending with no ack.
- The requester holds `memreq*`, `memrw*` and `memaddr*` until it sees its ack, then drops `memreq*` in the following cycle. Address and direction are latched at grant.
- Read beats:
  - `memrdata` = array[base+k], held at 0 outside read beats.
  - `memrvalid*` is asserted only toward the granted port.
- Write beats: array[base+k] ← `memwdata*` of the granted port at the edge ending a `memwready*` cycle.
- Reset returns the FSM to IDLE and clears the counters and grant state. Array contents are not cleared: words already written by a partial burst are kept, and the rest of that line is unchanged.
- Reset values: every output is 0.

## Timing
- Let t = the first cycle in which the state is IDLE and a request is high.
- Ack: high in cycle t+1 only.
- Beats: in cycles t+1+`LATENCY` … t+`LATENCY`+`LINE_WORDS`, one beat per cycle with no gaps and no backpressure. `memlast` is high on the final beat.
- `memdone*`: high in cycle t+1+`LATENCY`+`LINE_WORDS`. The state is DONE in that cycle and IDLE in the next.
- Earliest next acceptance: a request sampled in cycle t+2+`LATENCY`+`LINE_WORDS` is acked one cycle later.
- Read-after-write: a read issued after a write's `memdone` observes the written data.
- Total occupancy = `LATENCY`+`LINE_WORDS`+2 cycles per line (16 with defaults).

## Configuration
- `MAIN_MEM_RR_EN` defined: round-robin arbitration. A priority bit flips to the other port after each grant, and reset sets it to favour port 1. When both ports request continuously, grants alternate 1, 2, 1, 2 …
- Undefined: fixed priority. Port 1 always wins a tie, so port 2 can starve.

## Structure
- Package `main_mem_pkg` holds:
  - the state enum (IDLE, WAIT, RDBURST, WRBURST, DONE);
  - the default-parameter constants;
  - the derived widths: offset bits = log2(`LINE_WORDS`), index bits = log2(`DEPTH_WORDS`), counter width.
- Sub-module `main_mem_arb` is a two-requester arbiter, combinational grant plus the priority register. It contains the `MAIN_MEM_RR_EN` logic.
- The top level contains the FSM, the latency/beat counters, the latched request and the array.

## Test plan
- **Reset:** 3 cycles of reset → every output 0 and `busy`=0; reset asserted at beat 2 of a write burst → IDLE next cycle, words 0–1 updated, words 2–3 unchanged.
- **Refill:** preload word 0x40–0x43 = 0xA0–0xA3; `memreq`, `memrw`=0, `memaddr`=0x104 at t → `memack` at t+1, data 0xA0–0xA3 in t+11…t+14, `memlast` at t+14, `memdone` at t+15.
- **Writeback then read:** port 2 writes 0x11–0x14 to address 0x200, then reads 0x20C → reads return 0x11–0x14.
- **Tie:** both ports request at t, both as line reads to different line addresses (port 1 0x104, port 2 0x200) → port 1 acked at t+1. Port 2 is acked at t+17 (request sampled at t+16).
- **Arbitration mode:** both ports hold requests for 4 lines:
  - `MAIN_MEM_RR_EN` defined → grant order 1, 2, 1, 2;
  - undefined → grant order 1, 1, 1, 1 while port 1 keeps re-requesting.
- **Boundaries:** `memaddr`=0xFFFF_FFF0 with `DEPTH_WORDS`=1024 → accesses words 1020–1023; `LATENCY`=1 → first beat at t+2.
